// File: rtl/flash_dsm_pkg.sv
// Shared types and cell-model constants for the flash delta-sigma sense model.
package flash_dsm_pkg;

  typedef enum logic {
    ERASED     = 1'b0,
    PROGRAMMED = 1'b1
  } cell_state_e;

  localparam real I_CELL_MAX  = 10e-6;
  localparam real ERASED_OFFS = 0.5;
  localparam real PROG_OFFS   = -1.2;

endpackage

// File: rtl/flash_cell.sv
// Cell current versus gate voltage; the threshold offset depends on the cell state.
module flash_cell
  import flash_dsm_pkg::*;
(
  input  real         row_line,
  input  cell_state_e state,
  output real         icell
);

  real offs;

  always_comb begin
    offs  = (state == ERASED) ? ERASED_OFFS : PROG_OFFS;
    icell = I_CELL_MAX * ($tanh(row_line + offs) + 1.0) / 2.0;
  end

endmodule

// File: rtl/flash_dsm.sv
// First-order delta-sigma current sensor: the bit-line integrator is discharged by the
// cell and recharged by a charge pump whenever it falls below the comparator threshold.
module flash_dsm
  import flash_dsm_pkg::*;
#(
  parameter int  state    = 1,
  parameter real Cchrg    = 100e-15,
  parameter real vthp     = 0.5,
  parameter real vrefLsb  = 2.0e-3,
  parameter real clkFreq  = 100e6,
  parameter real Cint     = 1e-12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  real        vdd,
  input  real        vss,
  input  real        row_line,
  input  real        comp_vref,
  input  logic [7:0] chrg_trim,
  input  logic       en,
  output logic [8:0] out
);

  localparam real         TS      = 1.0 / (2.0 * clkFreq);
  localparam cell_state_e CELL_ST = (state == 0) ? ERASED : PROGRAMMED;
  localparam logic [8:0]  OUT_MAX = 9'd511;

  real  icell;
  real  vchg;
  real  dv_chg;
  real  vref_rel;
  real  vbl;
  real  vbl_dis;
  real  vbl_nxt;
  logic chg_evt;

  flash_cell u_cell (
    .row_line (row_line),
    .state    (CELL_ST),
    .icell    (icell)
  );

  // vbl is held relative to vss, so the comparator threshold is shifted to match
  always_comb begin
    vchg = vdd - vrefLsb * real'(chrg_trim) - vthp;
    if (vchg < 0.0) vchg = 0.0;
    dv_chg   = Cchrg * vchg / Cint;
    vref_rel = comp_vref - vss;
    vbl_dis  = vbl - icell * 2.0 * TS / Cint;
    chg_evt  = (vbl_dis < vref_rel);
    vbl_nxt  = chg_evt ? (vbl_dis + dv_chg) : vbl_dis;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vbl <= vref_rel;
      out <= '0;
    end else if (en) begin
      vbl <= vbl_nxt;
      if (chg_evt && (out != OUT_MAX)) out <= out + 9'd1;
    end
  end

endmodule

// File: tb/tb_flash_dsm.sv
// Directed bench for flash_dsm: one programmed and one erased instance share stimulus.
module tb_flash_dsm;

  logic       clk = 1'b0;
  logic       rst_n;
  real        vdd;
  real        vss;
  real        row_line;
  real        comp_vref;
  logic [7:0] chrg_trim;
  logic       en;
  logic [8:0] out_p;
  logic [8:0] out_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_dsm #(.state(1)) dut_p (
    .clk       (clk),
    .rst_n     (rst_n),
    .vdd       (vdd),
    .vss       (vss),
    .row_line  (row_line),
    .comp_vref (comp_vref),
    .chrg_trim (chrg_trim),
    .en        (en),
    .out       (out_p)
  );

  flash_dsm #(.state(0)) dut_e (
    .clk       (clk),
    .rst_n     (rst_n),
    .vdd       (vdd),
    .vss       (vss),
    .row_line  (row_line),
    .comp_vref (comp_vref),
    .chrg_trim (chrg_trim),
    .en        (en),
    .out       (out_e)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled on the falling edge
  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    run_cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    vdd       = 1.8;
    vss       = 0.0;
    row_line  = 0.0;
    comp_vref = 0.6;
    chrg_trim = 8'd147;
    @(negedge clk);

    // Vchg = 1.006 V -> 0.1006 V per event; programmed d = 8.317 mV, erased d = 73.11 mV
    do_reset();
    chk("reset_out_p", int'(out_p), 0);
    chk("reset_out_e", int'(out_e), 0);
    run_cycles(5);
    chk("idle_hold_p", int'(out_p), 0);

    en = 1'b1;
    run_cycles(1);
    chk("first_edge_p", int'(out_p), 1);
    chk("first_edge_e", int'(out_e), 1);
    run_cycles(255);
    chk("half_run_p", int'(out_p), 22);
    chk("half_run_e", int'(out_e), 187);

    en = 1'b0;
    run_cycles(20);
    chk("freeze_p", int'(out_p), 22);
    chk("freeze_e", int'(out_e), 187);

    en = 1'b1;
    run_cycles(256);
    chk("full_run_p", int'(out_p), 43);
    chk("full_run_e", int'(out_e), 373);
    en = 1'b0;

    // strong gate drive: both cells near 10 uA
    row_line = 5.0;
    do_reset();
    en = 1'b1;
    run_cycles(512);
    chk("row5_p", int'(out_p), 509);
    chk("row5_e", int'(out_e), 509);
    en = 1'b0;

    // no supply: no charge, counts every cycle, saturates
    row_line = 0.0;
    vdd      = 0.0;
    do_reset();
    en = 1'b1;
    run_cycles(1);
    chk("vdd0_step1", int'(out_p), 1);
    run_cycles(199);
    chk("vdd0_200", int'(out_p), 200);

    rst_n = 1'b0;
    run_cycles(1);
    chk("midreset_p", int'(out_p), 0);
    chk("midreset_e", int'(out_e), 0);
    rst_n = 1'b1;
    run_cycles(1);
    chk("resume_p", int'(out_p), 1);
    run_cycles(509);
    chk("vdd0_510", int'(out_p), 510);
    run_cycles(1);
    chk("sat_511", int'(out_p), 511);
    run_cycles(100);
    chk("sat_hold_p", int'(out_p), 511);
    chk("sat_hold_e", int'(out_e), 511);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
